alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the ALU state/next_state protocol.
//  - Accepts one operation at a time from the issue stage over a valid/ready handshake.
//  - Drives the ALU through `ALU_BEGIN then `ALU_RESULTS, and captures dst/dst_h/src0/src1.
//  - Presents the captured result to writeback over a valid/ready handshake.
//  - Adds a divide-by-zero pre-check and a watchdog for command codes that never raise next_state.
// PARAMETERS
//  DATA_W       32  operand/result width; must equal `DATA_SIZE0+1
//  TIMEOUT_CYC  16  clk_oe-qualified cycles allowed in BEGIN before abort; range 2..2**CNT_W-1
//  CNT_W        5   watchdog counter width
// PORTS
//  clk             in   1           system clock
//  rst             in   1           asynchronous active-high reset
//  clk_oe          in   1           clock enable; alternates 1,0 every clk; FSM advances only on clk_oe=1 edges
//  req_valid       in   1           issue stage offers an operation
//  req_ready       out  1           sequencer can accept (FSM in IDLE)
//  req_command     in   32          instruction word; [31:28] = cmd_code
//  req_src0        in   DATA_W      operand 0
//  req_src1        in   DATA_W      operand 1
//  alu_state       out  STATE_SIZE  `ALU_IDLE / `ALU_BEGIN / `ALU_RESULTS to ALU
//  alu_command     out  32          latched command to ALU
//  alu_src0        out  DATA_W      latched operand 0 to ALU
//  alu_src1        out  DATA_W      latched operand 1 to ALU
//  alu_next_state  in   1           ALU completion pulse
//  alu_dst         in   DATA_W      ALU dst_out
//  alu_dst_h       in   DATA_W      ALU dst_h_out
//  alu_src0_r      in   DATA_W      ALU src0_out
//  alu_src1_r      in   DATA_W      ALU src1_out
//  res_valid       out  1           result available
//  res_ready       in   1           writeback accepts the result
//  res_dst, res_dst_h, res_src0, res_src1   out  DATA_W   captured results
//  res_err         out  2           00 ok, 01 divide by zero, 10 watchdog timeout
//  busy            out  1           high in every FSM state except IDLE
// BEHAVIOUR
//  Reset: async. FSM=IDLE, alu_state=`ALU_IDLE, alu_command/alu_src*=0, all res_*=0,
//   res_valid=0, busy=0, req_ready=1, watchdog counter=0, done flag=0, begin_seen=0.
//   Reset mid-operation abandons the op; no result is emitted.
//  Registers change only on clk_oe=1 edges, except the done flag.
//  IDLE:
//   - On req_valid&req_ready: latch command and operands; clear counter, done flag and begin_seen.
//   - If cmd_code==`CMD_DIV and req_src1==0: go to HOLD with res_*=0 and res_err=01; ALU is not started.
//   - Otherwise go to BEGIN.
//  BEGIN (alu_state=`ALU_BEGIN):
//   - First clk_oe=1 edge sets begin_seen; each clk_oe=1 edge increments the counter.
//   - Done flag: sticky; set on any clk edge with begin_seen=1 and alu_next_state=1.
//     This rejects a stale pulse left from the previous operation.
//   - On a clk_oe=1 edge: if done flag is set, go to RESULTS.
//   - Else, if counter==TIMEOUT_CYC-1, go to HOLD with res_*=0 and res_err=10.
//   - If done and timeout occur on the same edge, done wins.
//  RESULTS (alu_state=`ALU_RESULTS): ALU outputs are valid combinationally here.
//   Next clk_oe=1 edge captures alu_dst/alu_dst_h/alu_src0_r/alu_src1_r into res_*, sets res_err=00, goes to HOLD.
//  HOLD (alu_state=`ALU_IDLE):
//   - res_valid=1; res_* held stable until res_valid&res_ready is seen on a clk_oe=1 edge.
//   - Then res_valid=0 and FSM goes to IDLE.
//   - No new request is accepted while in HOLD.
//  Latency, normal op with clk_oe alternating: res_valid rises 6 clk after the accept edge.
//   Divide by zero: res_valid rises on the accept edge itself.
//  Widths: res_* are pass-through; the sequencer does no arithmetic.
//   The counter saturates and never wraps.
// STRUCTURE
//  - Add `ALU_IDLE to states.v; use existing `ALU_BEGIN/`ALU_RESULTS and `CMD_DIV from cmd_codes.v.
//  - FSM encodings are localparams in this file.
//  - Single module; watchdog counter inline, no sub-module.
// TESTING (ALU instance as DUT partner, clk_oe toggling)
//  1. ADD src0=5 src1=7 -> res_dst=12, res_dst_h=0, res_err=00; res_valid 6 clk after accept.
//  2. MUL 0xFFFF_FFFF*2 -> res_dst=0xFFFF_FFFE, res_dst_h=1.
//  3. DIV 10/0 -> alu_state stays `ALU_IDLE; res_err=01, res_dst=0, res_valid on accept edge.
//  4. Unused cmd_code 4'hF -> after TIMEOUT_CYC clk_oe edges: res_err=10; next ADD is correct.
//  5. MOV src0=3 src1=9 with res_ready held low 10 clk -> res_dst=3, res_src0=9 stable; req_ready=0 throughout.
//  6. Back-to-back ADDs, second request waiting -> no stale next_state reuse; second result correct.
//     Then assert rst in BEGIN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
//   Shared ALU protocol definitions for the sequencer and its partners:
//   ALU state-bus encodings, command codes carried in command[31:28],
//   and the result error codes reported to writeback.
package alu_sequencer_pkg;

  localparam int STATE_SIZE = 2;

  // ALU state bus as seen by the ALU
  localparam logic [STATE_SIZE-1:0] ALU_IDLE    = 2'd0;
  localparam logic [STATE_SIZE-1:0] ALU_BEGIN   = 2'd1;
  localparam logic [STATE_SIZE-1:0] ALU_RESULTS = 2'd2;

  // Command codes (instruction word bits [31:28])
  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_MUL = 4'h3;
  localparam logic [3:0] CMD_DIV = 4'h4;
  localparam logic [3:0] CMD_MOV = 4'h5;

  // Result error codes
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_DIV0    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic [3:0] cmd_code(input logic [31:0] command);
    return command[31:28];
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Initiator side of the ALU state/next_state protocol. Takes one operation
//   at a time from issue (req_valid/req_ready), walks the ALU through BEGIN and
//   RESULTS, captures dst/dst_h/src0/src1 and offers them to writeback
//   (res_valid/res_ready). Divides by zero are rejected without starting the
//   ALU; a watchdog aborts commands whose next_state never arrives.
// Ports
//   clk, rst (async, active-high), clk_oe (advance enable, alternating)
//   req_valid/req_ready/req_command/req_src0/req_src1 : issue handshake
//   alu_state/alu_command/alu_src0/alu_src1           : drive to ALU
//   alu_next_state/alu_dst/alu_dst_h/alu_src0_r/alu_src1_r : ALU returns
//   res_valid/res_ready/res_dst/res_dst_h/res_src0/res_src1/res_err : writeback
//   busy : high whenever the sequencer is not idle
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_oe,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_command,
  input  logic [DATA_W-1:0]     req_src0,
  input  logic [DATA_W-1:0]     req_src1,
  output logic [STATE_SIZE-1:0] alu_state,
  output logic [31:0]           alu_command,
  output logic [DATA_W-1:0]     alu_src0,
  output logic [DATA_W-1:0]     alu_src1,
  input  logic                  alu_next_state,
  input  logic [DATA_W-1:0]     alu_dst,
  input  logic [DATA_W-1:0]     alu_dst_h,
  input  logic [DATA_W-1:0]     alu_src0_r,
  input  logic [DATA_W-1:0]     alu_src1_r,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_dst,
  output logic [DATA_W-1:0]     res_dst_h,
  output logic [DATA_W-1:0]     res_src0,
  output logic [DATA_W-1:0]     res_src1,
  output logic [1:0]            res_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BEGIN   = 2'd1,
    S_RESULTS = 2'd2,
    S_HOLD    = 2'd3
  } seq_state_e;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] wd_cnt_q;
  logic             begin_seen_q;
  logic             done_q;
  logic             accept;
  logic             div_by_zero;
  logic             timeout;

  assign accept      = clk_oe && (state_q == S_IDLE) && req_valid;
  assign div_by_zero = (cmd_code(req_command) == CMD_DIV) && (req_src1 == '0);
  assign timeout     = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    alu_state = ALU_IDLE;
    unique case (state_q)
      S_BEGIN:   alu_state = ALU_BEGIN;
      S_RESULTS: alu_state = ALU_RESULTS;
      default:   alu_state = ALU_IDLE;
    endcase
    if (clk_oe) begin
      unique case (state_q)
        S_IDLE:    if (req_valid) state_d = div_by_zero ? S_HOLD : S_BEGIN;
        // a completion seen on the same edge as the timeout takes priority
        S_BEGIN:   if (done_q) state_d = S_RESULTS;
                   else if (timeout) state_d = S_HOLD;
        S_RESULTS: state_d = S_HOLD;
        S_HOLD:    if (res_ready) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Operand latch, watchdog and result capture; all advance on clk_oe edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_command  <= '0;
      alu_src0     <= '0;
      alu_src1     <= '0;
      res_dst      <= '0;
      res_dst_h    <= '0;
      res_src0     <= '0;
      res_src1     <= '0;
      res_err      <= ERR_OK;
      wd_cnt_q     <= '0;
      begin_seen_q <= 1'b0;
    end else if (clk_oe) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            alu_command  <= req_command;
            alu_src0     <= req_src0;
            alu_src1     <= req_src1;
            wd_cnt_q     <= '0;
            begin_seen_q <= 1'b0;
            if (div_by_zero) begin
              res_dst   <= '0;
              res_dst_h <= '0;
              res_src0  <= '0;
              res_src1  <= '0;
              res_err   <= ERR_DIV0;
            end
          end
        end
        S_BEGIN: begin
          begin_seen_q <= 1'b1;
          if (wd_cnt_q != '1) wd_cnt_q <= wd_cnt_q + CNT_W'(1);
          if (!done_q && timeout) begin
            res_dst   <= '0;
            res_dst_h <= '0;
            res_src0  <= '0;
            res_src1  <= '0;
            res_err   <= ERR_TIMEOUT;
          end
        end
        S_RESULTS: begin
          res_dst   <= alu_dst;
          res_dst_h <= alu_dst_h;
          res_src0  <= alu_src0_r;
          res_src1  <= alu_src1_r;
          res_err   <= ERR_OK;
        end
        default: ;
      endcase
    end
  end

  // Done flag samples next_state on every clk edge so a one-clk pulse between
  // clk_oe edges is not lost. It only arms after the first clk_oe edge in
  // BEGIN, which keeps a pulse left over from the previous op from counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                done_q <= 1'b0;
    else if (accept)                        done_q <= 1'b0;
    else if (begin_seen_q && alu_next_state) done_q <= 1'b1;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a small behavioural ALU partner and
//   clk_oe alternating 1,0 every clk.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 5;

  logic                  clk, rst, clk_oe;
  logic                  req_valid, req_ready;
  logic [31:0]           req_command;
  logic [DATA_W-1:0]     req_src0, req_src1;
  logic [STATE_SIZE-1:0] alu_state;
  logic [31:0]           alu_command;
  logic [DATA_W-1:0]     alu_src0, alu_src1;
  logic                  alu_next_state = 1'b0;
  logic [DATA_W-1:0]     alu_dst, alu_dst_h, alu_src0_r, alu_src1_r;
  logic                  res_valid, res_ready;
  logic [DATA_W-1:0]     res_dst, res_dst_h, res_src0, res_src1;
  logic [1:0]            res_err;
  logic                  busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_sequencer #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clk_oe(clk_oe),
    .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
    .req_src0(req_src0), .req_src1(req_src1),
    .alu_state(alu_state), .alu_command(alu_command),
    .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_next_state(alu_next_state), .alu_dst(alu_dst), .alu_dst_h(alu_dst_h),
    .alu_src0_r(alu_src0_r), .alu_src1_r(alu_src1_r),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_dst(res_dst), .res_dst_h(res_dst_h), .res_src0(res_src0), .res_src1(res_src1),
    .res_err(res_err), .busy(busy)
  );

  // clk period 10; clk_oe flips on each falling edge so posedges alternate 1,0
  initial begin
    clk    = 1'b0;
    clk_oe = 1'b0;
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      clk_oe = ~clk_oe;
    end
  end

  // Behavioural ALU partner: results combinational from the latched operands,
  // next_state raised one clk after it sees BEGIN for a known command.
  logic [3:0]  m_code;
  logic        m_known;
  logic [63:0] m_prod;
  always_comb begin
    m_code     = alu_command[31:28];
    m_prod     = {32'd0, alu_src0} * {32'd0, alu_src1};
    m_known    = (m_code == CMD_ADD) || (m_code == CMD_MUL) ||
                 (m_code == CMD_DIV) || (m_code == CMD_MOV);
    alu_dst    = '0;
    alu_dst_h  = '0;
    case (m_code)
      CMD_ADD: alu_dst = alu_src0 + alu_src1;
      CMD_MUL: begin alu_dst = m_prod[31:0]; alu_dst_h = m_prod[63:32]; end
      CMD_DIV: if (alu_src1 != '0) begin
                 alu_dst   = alu_src0 / alu_src1;
                 alu_dst_h = alu_src0 % alu_src1;
               end
      CMD_MOV: alu_dst = alu_src0;
      default: ;
    endcase
    alu_src0_r = alu_src1;
    alu_src1_r = alu_src0;
  end

  always @(posedge clk) alu_next_state <= (alu_state == ALU_BEGIN) && m_known;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns at negedge+1 with the coming posedge being a clk_oe=1 edge in IDLE
  task automatic wait_slot(input string name);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (!(clk_oe && req_ready) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, ".slot"}, 64'(clk_oe & req_ready), 64'd1);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, ".drain"}, 64'(res_valid), 64'd0);
  endtask

  task automatic do_op(input string name, input logic [3:0] code,
                       input logic [31:0] s0, input logic [31:0] s1,
                       input int exp_lat, input logic [31:0] e_dst, input logic [31:0] e_dsth,
                       input logic [31:0] e_s0, input logic [31:0] e_s1,
                       input logic [1:0] e_err, input bit hold_low);
    res_ready = !hold_low;
    wait_slot(name);
    req_command = {code, 28'h0};
    req_src0    = s0;
    req_src1    = s1;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_result(name, exp_lat);
    chk({name, ".dst"},   64'(res_dst),   64'(e_dst));
    chk({name, ".dst_h"}, 64'(res_dst_h), 64'(e_dsth));
    chk({name, ".src0"},  64'(res_src0),  64'(e_s0));
    chk({name, ".src1"},  64'(res_src1),  64'(e_s1));
    chk({name, ".err"},   64'(res_err),   64'(e_err));
    chk({name, ".astate"}, 64'(alu_state), 64'(ALU_IDLE));
    chk({name, ".busy"},  64'(busy),      64'd1);
    if (hold_low) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk({name, ".hold_valid"}, 64'(res_valid), 64'd1);
        chk({name, ".hold_dst"},   64'(res_dst),   64'(e_dst));
        chk({name, ".hold_src0"},  64'(res_src0),  64'(e_s0));
        chk({name, ".hold_ready"}, 64'(req_ready), 64'd0);
      end
      res_ready = 1'b1;
    end
    drain(name);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hits;
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_command = '0;
    req_src0    = '0;
    req_src1    = '0;
    res_ready   = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    chk("rst.busy",      64'(busy),      64'd0);
    chk("rst.res_valid", 64'(res_valid), 64'd0);
    chk("rst.alu_state", 64'(alu_state), 64'(ALU_IDLE));
    chk("rst.alu_cmd",   64'(alu_command), 64'd0);
    chk("rst.res_err",   64'(res_err),   64'd0);
    @(negedge clk); #1 rst = 1'b0;

    // 1. ADD 5+7
    do_op("add", CMD_ADD, 32'd5, 32'd7, 6, 32'd12, 32'd0, 32'd7, 32'd5, ERR_OK, 1'b0);
    // 2. MUL 0xFFFFFFFF*2
    do_op("mul", CMD_MUL, 32'hFFFF_FFFF, 32'd2, 6, 32'hFFFF_FFFE, 32'd1,
          32'd2, 32'hFFFF_FFFF, ERR_OK, 1'b0);
    // 3. DIV 10/0 rejected on the accept edge; DIV 10/3 runs normally
    do_op("div0", CMD_DIV, 32'd10, 32'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, ERR_DIV0, 1'b0);
    do_op("div", CMD_DIV, 32'd10, 32'd3, 6, 32'd3, 32'd1, 32'd3, 32'd10, ERR_OK, 1'b0);
    // 4. Unknown command times out after TIMEOUT_CYC clk_oe edges
    do_op("wdog", 4'hF, 32'd1, 32'd2, 2 * TIMEOUT_CYC, 32'd0, 32'd0, 32'd0, 32'd0,
          ERR_TIMEOUT, 1'b0);
    do_op("add2", CMD_ADD, 32'd20, 32'd22, 6, 32'd42, 32'd0, 32'd22, 32'd20, ERR_OK, 1'b0);
    // 5. MOV with writeback stalled 10 clk
    do_op("mov", CMD_MOV, 32'd3, 32'd9, 6, 32'd3, 32'd0, 32'd9, 32'd3, ERR_OK, 1'b1);

    // 6. Back-to-back ADDs with the second request already waiting
    res_ready = 1'b1;
    wait_slot("b2b1");
    req_command = {CMD_ADD, 28'h0};
    req_src0    = 32'd100;
    req_src1    = 32'd23;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_src0 = 32'h10;
    req_src1 = 32'h20;
    wait_result("b2b1", 6);
    chk("b2b1.dst", 64'(res_dst), 64'd123);
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b.idle", 64'(busy), 64'd0);
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b2.accepted", 64'(busy), 64'd1);
    req_valid = 1'b0;
    wait_result("b2b2", 6);
    chk("b2b2.dst",  64'(res_dst),  64'h30);
    chk("b2b2.src0", 64'(res_src0), 64'h20);
    chk("b2b2.err",  64'(res_err),  64'(ERR_OK));
    drain("b2b2");

    // Reset in BEGIN abandons the op
    wait_slot("rstop");
    req_command = {CMD_ADD, 28'h0};
    req_src0    = 32'd1;
    req_src1    = 32'd1;
    req_valid   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rstop.in_begin", 64'(alu_state), 64'(ALU_BEGIN));
    rst = 1'b1;
    #1;
    chk("rstop.alu_state", 64'(alu_state), 64'(ALU_IDLE));
    chk("rstop.busy",      64'(busy),      64'd0);
    chk("rstop.req_ready", 64'(req_ready), 64'd1);
    chk("rstop.res_valid", 64'(res_valid), 64'd0);
    chk("rstop.alu_cmd",   64'(alu_command), 64'd0);
    chk("rstop.alu_src0",  64'(alu_src0),  64'd0);
    chk("rstop.res_dst",   64'(res_dst),   64'd0);
    chk("rstop.res_src0",  64'(res_src0),  64'd0);
    @(negedge clk); #1 rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (res_valid) hits++;
    end
    chk("rstop.no_result", 64'(hits), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
